// File: rtl/bus_controller.sv
`default_nettype none
// ============================================================================
//  Module   : bus_controller
//  Purpose  : Arbitrates Icache / Dcache miss traffic onto the external word
//             bus. Handles line refills, dirty-line write-backs and uncached
//             single-word accesses, and raises ready pulses and core_WAIT_o.
//  Revision : 1.0  initial release
// ============================================================================
module bus_controller #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Icache_miss_i,
    input  logic [ADDR_W-1:0]          Icache_addr_i,
    input  logic                       Dcache_miss_i,
    input  logic [ADDR_W-1:0]          Dcache_addr_i,
    input  logic                       Dcache_wb_i,
    input  logic [ADDR_W-1:0]          Dcache_wb_addr_i,
    input  logic [32*LINE_WORDS-1:0]   Dcache_wb_line_i,
    input  logic                       Dcache_unc_i,
    input  logic                       Dcache_unc_we_i,
    input  logic [ADDR_W-1:0]          Dcache_unc_addr_i,
    input  logic [31:0]                Dcache_unc_wdata_i,
    output logic                       bus_req_o,
    output logic                       bus_we_o,
    output logic [ADDR_W-1:0]          bus_addr_o,
    output logic [31:0]                bus_wdata_o,
    input  logic                       bus_ack_i,
    input  logic [31:0]                bus_rdata_i,
    output logic                       bc_Icache_ready_o,
    output logic [32*LINE_WORDS-1:0]   bc_Icache_line_o,
    output logic                       bc_Dcache_ready_o,
    output logic [32*LINE_WORDS-1:0]   bc_Dcache_line_o,
    output logic                       core_WAIT_o
);

    localparam int                CNT_W     = $clog2(LINE_WORDS);
    localparam int                LINE_W    = 32 * LINE_WORDS;
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_D_UNC  = 3'd1,
        S_D_WB   = 3'd2,
        S_D_FILL = 3'd3,
        S_I_FILL = 3'd4,
        S_DONE_I = 3'd5,
        S_DONE_D = 3'd6
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    beat_q;
    logic [ADDR_W-1:0]   fill_base_q;
    logic [ADDR_W-1:0]   wb_base_q;
    logic [LINE_W-1:0]   wb_line_q;
    logic                unc_we_q;
    logic [ADDR_W-1:0]   unc_addr_q;
    logic [31:0]         unc_wdata_q;
    logic                bus_req_q;
    logic                bus_we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [31:0]         bus_wdata_q;
    logic [LINE_W-1:0]   i_line_q;
    logic [LINE_W-1:0]   d_line_q;
    logic                i_ready_q;
    logic                d_ready_q;
    logic                wait_q;

    logic [CNT_W-1:0]    beat_d;
    logic [ADDR_W-1:0]   fill_addr_d;
    logic [ADDR_W-1:0]   wb_addr_d;
    logic [31:0]         wb_word_d;

    // Address and victim word for the beat that follows the current one
    always_comb begin
        beat_d      = beat_q + CNT_W'(1);
        fill_addr_d = fill_base_q + ADDR_W'({beat_d, 2'b00});
        wb_addr_d   = wb_base_q + ADDR_W'({beat_d, 2'b00});
        wb_word_d   = wb_line_q[{beat_d, 5'd0} +: 32];
    end

    // Controller FSM: arbitration, burst sequencing and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            fill_base_q <= '0;
            wb_base_q   <= '0;
            wb_line_q   <= '0;
            unc_we_q    <= 1'b0;
            unc_addr_q  <= '0;
            unc_wdata_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            i_line_q    <= '0;
            d_line_q    <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            wait_q      <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    beat_q <= '0;
                    if (Dcache_unc_i) begin
                        unc_we_q    <= Dcache_unc_we_i;
                        unc_addr_q  <= Dcache_unc_addr_i;
                        unc_wdata_q <= Dcache_unc_wdata_i;
                        state_q     <= S_D_UNC;
                    end else if (Dcache_miss_i) begin
                        fill_base_q <= Dcache_addr_i & ~OFF_MASK;
                        wb_base_q   <= Dcache_wb_addr_i & ~OFF_MASK;
                        wb_line_q   <= Dcache_wb_line_i;
                        state_q     <= Dcache_wb_i ? S_D_WB : S_D_FILL;
                    end else if (Icache_miss_i) begin
                        fill_base_q <= Icache_addr_i & ~OFF_MASK;
                        state_q     <= S_I_FILL;
                    end
                end
                S_D_UNC: begin
                    // First cycle presents the beat; core is frozen until its ack
                    if (!bus_req_q) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= unc_we_q;
                        bus_addr_q  <= unc_addr_q;
                        bus_wdata_q <= unc_wdata_q;
                        wait_q      <= 1'b1;
                    end else if (bus_ack_i) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        wait_q    <= 1'b0;
                        if (!unc_we_q) begin
                            d_line_q[31:0] <= bus_rdata_i;
                        end
                        d_ready_q <= 1'b1;
                        state_q   <= S_DONE_D;
                    end
                end
                S_D_WB: begin
                    if (!bus_req_q) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= wb_base_q;
                        bus_wdata_q <= wb_line_q[31:0];
                    end else if (bus_ack_i) begin
                        if (beat_q == LAST_BEAT) begin
                            // Roll straight into the refill with no idle bus cycle
                            beat_q      <= '0;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= fill_base_q;
                            bus_wdata_q <= '0;
                            state_q     <= S_D_FILL;
                        end else begin
                            beat_q      <= beat_d;
                            bus_addr_q  <= wb_addr_d;
                            bus_wdata_q <= wb_word_d;
                        end
                    end
                end
                S_D_FILL, S_I_FILL: begin
                    if (!bus_req_q) begin
                        bus_req_q  <= 1'b1;
                        bus_we_q   <= 1'b0;
                        bus_addr_q <= fill_base_q;
                    end else if (bus_ack_i) begin
                        if (state_q == S_I_FILL) begin
                            i_line_q[{beat_q, 5'd0} +: 32] <= bus_rdata_i;
                        end else begin
                            d_line_q[{beat_q, 5'd0} +: 32] <= bus_rdata_i;
                        end
                        if (beat_q == LAST_BEAT) begin
                            beat_q    <= '0;
                            bus_req_q <= 1'b0;
                            if (state_q == S_I_FILL) begin
                                i_ready_q <= 1'b1;
                                state_q   <= S_DONE_I;
                            end else begin
                                d_ready_q <= 1'b1;
                                state_q   <= S_DONE_D;
                            end
                        end else begin
                            beat_q     <= beat_d;
                            bus_addr_q <= fill_addr_d;
                        end
                    end
                end
                S_DONE_I, S_DONE_D: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_req_o         = bus_req_q;
    assign bus_we_o          = bus_we_q;
    assign bus_addr_o        = bus_addr_q;
    assign bus_wdata_o       = bus_wdata_q;
    assign bc_Icache_ready_o = i_ready_q;
    assign bc_Icache_line_o  = i_line_q;
    assign bc_Dcache_ready_o = d_ready_q;
    assign bc_Dcache_line_o  = d_line_q;
    assign core_WAIT_o       = wait_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_controller
//  Purpose  : Self-checking bench for bus_controller: random-wait bus slave,
//             expected-beat scoreboard and line/latency/WAIT reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_controller;

    localparam int LW     = 4;
    localparam int LINE_W = 32 * LW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              Icache_miss_i = 1'b0;
    logic [31:0]       Icache_addr_i = '0;
    logic              Dcache_miss_i = 1'b0;
    logic [31:0]       Dcache_addr_i = '0;
    logic              Dcache_wb_i = 1'b0;
    logic [31:0]       Dcache_wb_addr_i = '0;
    logic [LINE_W-1:0] Dcache_wb_line_i = '0;
    logic              Dcache_unc_i = 1'b0;
    logic              Dcache_unc_we_i = 1'b0;
    logic [31:0]       Dcache_unc_addr_i = '0;
    logic [31:0]       Dcache_unc_wdata_i = '0;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [31:0]       bus_addr_o;
    logic [31:0]       bus_wdata_o;
    logic              bus_ack_i = 1'b0;
    logic [31:0]       bus_rdata_i = '0;
    logic              bc_Icache_ready_o;
    logic [LINE_W-1:0] bc_Icache_line_o;
    logic              bc_Dcache_ready_o;
    logic [LINE_W-1:0] bc_Dcache_line_o;
    logic              core_WAIT_o;

    always #5 clk = ~clk;

    bus_controller #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Icache_miss_i(Icache_miss_i), .Icache_addr_i(Icache_addr_i),
        .Dcache_miss_i(Dcache_miss_i), .Dcache_addr_i(Dcache_addr_i),
        .Dcache_wb_i(Dcache_wb_i), .Dcache_wb_addr_i(Dcache_wb_addr_i),
        .Dcache_wb_line_i(Dcache_wb_line_i),
        .Dcache_unc_i(Dcache_unc_i), .Dcache_unc_we_i(Dcache_unc_we_i),
        .Dcache_unc_addr_i(Dcache_unc_addr_i), .Dcache_unc_wdata_i(Dcache_unc_wdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .bc_Icache_ready_o(bc_Icache_ready_o), .bc_Icache_line_o(bc_Icache_line_o),
        .bc_Dcache_ready_o(bc_Dcache_ready_o), .bc_Dcache_line_o(bc_Dcache_line_o),
        .core_WAIT_o(core_WAIT_o)
    );

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    force_w  = -1;
    int    wait_seen = 0;
    int    wait_exp  = 0;
    int    beats_acked = 0;
    bit    in_unc = 1'b0;
    int    wcnt = 0;
    bit    new_beat = 1'b1;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Simple memory image returned by the slave on reads
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    // Bus slave: random wait states, checks each accepted beat against the scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (core_WAIT_o) wait_seen++;
        if (!rst_n) begin
            bus_ack_i = 1'b0;
            new_beat  = 1'b1;
        end else if (!bus_req_o) begin
            bus_ack_i   = 1'($urandom_range(0, 1));
            bus_rdata_i = $urandom;
            new_beat    = 1'b1;
        end else begin
            if (new_beat) begin
                wcnt = (force_w >= 0) ? force_w : int'($urandom_range(0, 3));
                if (in_unc) wait_exp = wcnt + 1;
                new_beat = 1'b0;
            end
            if (wcnt == 0) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = mem(bus_addr_o);
                new_beat    = 1'b1;
                beats_acked++;
                chk("extra_beat", LINE_W'(exp_q.size() == 0), '0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_addr", bus_addr_o, e.a);
                    chk("beat_we", bus_we_o, e.we);
                    if (e.we) chk("beat_wdata", bus_wdata_o, e.d);
                end
            end else begin
                bus_ack_i = 1'b0;
                wcnt--;
            end
        end
    end

    task automatic push_fill(input logic [31:0] a);
        for (int k = 0; k < LW; k++) exp_q.push_back('{line_base(a) + 32'(4 * k), 1'b0, 32'h0});
    endtask

    // One transaction (optionally Icache + Dcache together); returns cycles to first ready
    task automatic run_txn(input bit do_i, input logic [31:0] ia,
                           input bit do_d, input bit d_unc, input bit d_wb, input bit unc_we,
                           input logic [31:0] da, input logic [31:0] wba,
                           input logic [LINE_W-1:0] victim, input logic [31:0] wdata,
                           input int d_delay, output int lat);
        logic [LINE_W-1:0] i_exp, d_exp;
        bit i_done, d_done;
        int cyc;
        in_unc    = do_d && d_unc;
        wait_exp  = 0;
        wait_seen = 0;
        if (do_i && d_delay > 0) push_fill(ia);
        if (do_d) begin
            if (d_unc) begin
                exp_q.push_back('{da, unc_we, wdata});
            end else begin
                if (d_wb)
                    for (int k = 0; k < LW; k++)
                        exp_q.push_back('{line_base(wba) + 32'(4 * k), 1'b1, victim[32*k +: 32]});
                push_fill(da);
            end
        end
        if (do_i && d_delay == 0) push_fill(ia);
        for (int k = 0; k < LW; k++) begin
            i_exp[32*k +: 32] = mem(line_base(ia) + 32'(4 * k));
            d_exp[32*k +: 32] = mem(line_base(da) + 32'(4 * k));
        end
        Icache_miss_i = do_i;
        Icache_addr_i = ia;
        Dcache_addr_i = da;
        Dcache_wb_i = d_wb;
        Dcache_wb_addr_i = wba;
        Dcache_wb_line_i = victim;
        Dcache_unc_we_i = unc_we;
        Dcache_unc_addr_i = da;
        Dcache_unc_wdata_i = wdata;
        if (d_delay == 0) begin
            Dcache_miss_i = do_d && !d_unc;
            Dcache_unc_i  = do_d && d_unc;
        end
        i_done = !do_i;
        d_done = !do_d;
        cyc = 0;
        lat = 0;
        while (!(i_done && d_done) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bc_Icache_ready_o) begin
                chk("i_ready_unexpected", LINE_W'(i_done), '0);
                if (!i_done) chk("i_line", bc_Icache_line_o, i_exp);
                if (lat == 0) lat = cyc;
                i_done = 1'b1;
                Icache_miss_i = 1'b0;
            end
            if (bc_Dcache_ready_o) begin
                chk("d_ready_unexpected", LINE_W'(d_done), '0);
                if (!d_done && !d_unc) chk("d_line", bc_Dcache_line_o, d_exp);
                if (!d_done && d_unc && !unc_we) chk("unc_rdata", bc_Dcache_line_o[31:0], mem(da));
                if (lat == 0) lat = cyc;
                d_done = 1'b1;
                Dcache_miss_i = 1'b0;
                Dcache_unc_i  = 1'b0;
            end
            if (do_d && d_delay > 0 && cyc == d_delay) begin
                Dcache_miss_i = !d_unc;
                Dcache_unc_i  = d_unc;
            end
        end
        chk("txn_timeout", LINE_W'(i_done && d_done), 1);
        chk("beats_left", exp_q.size(), 0);
        chk("wait_cycles", wait_seen, wait_exp);
        Icache_miss_i = 1'b0;
        Dcache_miss_i = 1'b0;
        Dcache_unc_i  = 1'b0;
        Dcache_wb_i   = 1'b0;
        exp_q.delete();
        in_unc = 1'b0;
    endtask

    initial begin
        int lat, pulses, reqs, kind, c;
        logic [LINE_W-1:0] v;
        repeat (3) @(negedge clk);
        chk("rst_req", bus_req_o, 0);
        chk("rst_we", bus_we_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_wdata", bus_wdata_o, 0);
        chk("rst_irdy", bc_Icache_ready_o, 0);
        chk("rst_drdy", bc_Dcache_ready_o, 0);
        chk("rst_wait", core_WAIT_o, 0);
        chk("rst_iline", bc_Icache_line_o, 0);
        chk("rst_dline", bc_Dcache_line_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req", bus_req_o, 0);

        // Icache fill, zero-wait: ready at cycle LW+2
        force_w = 0;
        run_txn(1, 32'h0000_1234, 0, 0, 0, 0, 0, 0, '0, 0, 0, lat);
        chk("i_fill_latency", lat, LW + 2);
        force_w = -1;

        // Dirty victim write-back then refill
        v = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        run_txn(0, 0, 1, 0, 1, 0, 32'h3008, 32'h2000, v, 0, 0, lat);

        // Uncached read with 3 wait cycles: WAIT high 4 cycles
        force_w = 3;
        run_txn(0, 0, 1, 1, 0, 0, 32'h8000_0004, 0, '0, 0, 0, lat);
        force_w = -1;

        // Uncached write
        run_txn(0, 0, 1, 1, 0, 1, 32'h8000_0010, 0, '0, 32'hCAFE_F00D, 0, lat);

        // Simultaneous Icache and Dcache miss: Dcache served first
        run_txn(1, 32'h4450, 1, 0, 0, 0, 32'h5514, 0, '0, 0, 0, lat);

        // Dcache miss raised during Icache fill: Icache burst completes first
        v = {$urandom, $urandom, $urandom, $urandom};
        run_txn(1, 32'h6000, 1, 0, 1, 0, 32'h7004, 32'h7100, v, 0, 2, lat);

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 4));
            v = {$urandom, $urandom, $urandom, $urandom};
            case (kind)
                0: run_txn(1, $urandom, 0, 0, 0, 0, 0, 0, '0, 0, 0, lat);
                1: run_txn(0, 0, 1, 0, 0, 0, $urandom, 0, '0, 0, 0, lat);
                2: run_txn(0, 0, 1, 0, 1, 0, $urandom, $urandom, v, 0, 0, lat);
                3: run_txn(0, 0, 1, 1, 0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                           0, '0, $urandom, 0, lat);
                default: run_txn(1, $urandom, 1, 0, 1'($urandom_range(0, 1)), 0, $urandom,
                                 $urandom, v, 0, 0, lat);
            endcase
        end

        // Reset during beat 2 of an Icache fill
        force_w = 0;
        push_fill(32'h9000);
        Icache_addr_i = 32'h9000;
        Icache_miss_i = 1'b1;
        c = 0;
        while (!(bus_req_o && bus_addr_o == 32'h9008) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("reach_beat2", LINE_W'(c < 50), 1);
        rst_n = 1'b0;
        Icache_miss_i = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_req", bus_req_o, 0);
        chk("mid_rst_addr", bus_addr_o, 0);
        chk("mid_rst_irdy", bc_Icache_ready_o, 0);
        chk("mid_rst_iline", bc_Icache_line_o, 0);
        chk("mid_rst_wait", core_WAIT_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (bc_Icache_ready_o || bc_Dcache_ready_o) pulses++;
            if (bus_req_o) reqs++;
        end
        chk("ready_after_reset", pulses, 0);
        chk("req_after_reset", reqs, 0);
        force_w = -1;

        // Recovery after reset
        run_txn(1, 32'hA01C, 0, 0, 0, 0, 0, 0, '0, 0, 0, lat);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
